// File: rtl/qerv_bufreg_ctrl.sv
// ============================================================================
//  Module   : qerv_bufreg_ctrl
//  Purpose  : Sequencer for the quad-serial buffer register. Runs an
//             address/operand init pass, an optional bus-wait or coarse-shift
//             phase, then a readout pass, and pulses done on completion.
//  Options  : QERV_DBUS_TIMEOUT_EN adds an 8-bit bus watchdog and o_bus_err.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qerv_bufreg_ctrl #(
  parameter int BITS_PER_CYCLE = 4,
  parameter int LB = (BITS_PER_CYCLE > 1) ? $clog2(BITS_PER_CYCLE) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic [4:0]    i_shamt,
  input  logic          i_dbus_ack,
  output logic          o_ready,
  output logic          o_done,
  output logic [4:0]    o_cnt,
  output logic          o_cnt0,
  output logic          o_cnt1,
  output logic          o_bufreg_en,
  output logic          o_bufreg_init,
  output logic          o_shift_op,
  output logic [LB-1:0] o_shift_counter_lsb,
`ifdef QERV_DBUS_TIMEOUT_EN
  output logic          o_bus_err,
`endif
  output logic          o_dbus_cyc
);

  // Coarse shift counts whole slices, so it uses the shamt bits above LB.
  localparam int         CW        = 5 - LB;
  localparam logic [4:0] CNT_STEP  = 5'(BITS_PER_CYCLE);
  localparam logic [4:0] CNT_LAST  = 5'(32 - BITS_PER_CYCLE);
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_SHIFT  = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    BUS   = 3'd2,
    SHIFT = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [4:0]    cnt;
  logic [1:0]    op;
  logic [4:0]    shamt;
  logic [CW-1:0] shift_cnt;
  logic [CW-1:0] coarse;
  logic          last_slice;
  logic          pass_active;

  assign coarse      = shamt[4:LB];
  assign last_slice  = (cnt == CNT_LAST);
  assign pass_active = (state == INIT) || (state == RUN);

`ifdef QERV_DBUS_TIMEOUT_EN
  logic [7:0] watchdog;
  logic       bus_err;
  logic       timeout_hit;
  assign o_bus_err = bus_err;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    state_next    = state;
    o_ready       = 1'b0;
    o_done        = 1'b0;
    o_bufreg_en   = 1'b0;
    o_bufreg_init = 1'b0;
    o_dbus_cyc    = 1'b0;
`ifdef QERV_DBUS_TIMEOUT_EN
    timeout_hit   = 1'b0;
`endif
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) state_next = INIT;
      end
      INIT: begin
        o_bufreg_en   = 1'b1;
        o_bufreg_init = 1'b1;
        if (last_slice) begin
          if (op == OP_MEM)             state_next = BUS;
          else if (op == OP_SHIFT)      state_next = (coarse != '0) ? SHIFT : RUN;
          else                          state_next = DONE;
        end
      end
      BUS: begin
        o_dbus_cyc = 1'b1;
        if (i_dbus_ack) begin
          state_next = RUN;
`ifdef QERV_DBUS_TIMEOUT_EN
        end else if (watchdog == 8'd254) begin
          // 255th wait cycle with no ack: give up and report the error.
          state_next  = DONE;
          timeout_hit = 1'b1;
`endif
        end
      end
      SHIFT: begin
        o_bufreg_en = 1'b1;
        if (shift_cnt == CW'(1)) state_next = RUN;
      end
      RUN: begin
        o_bufreg_en = 1'b1;
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operation latch, slice counter and coarse shift down-counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op        <= 2'b00;
      shamt     <= 5'd0;
      cnt       <= 5'd0;
      shift_cnt <= '0;
    end else begin
      if (state == IDLE && i_start) begin
        op    <= i_op;
        shamt <= i_shamt;
      end
      // Wraps from CNT_LAST back to 0 at the end of each pass.
      if (pass_active) cnt <= cnt + CNT_STEP;
      else             cnt <= 5'd0;
      if (state == INIT)       shift_cnt <= coarse;
      else if (state == SHIFT) shift_cnt <= shift_cnt - CW'(1);
    end
  end

`ifdef QERV_DBUS_TIMEOUT_EN
  // Bus watchdog counts wait cycles; error flag lives only in the DONE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      watchdog <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      if (state == BUS) watchdog <= watchdog + 8'd1;
      else              watchdog <= 8'd0;
      bus_err <= timeout_hit;
    end
  end
`endif

  assign o_cnt               = cnt;
  assign o_cnt0              = pass_active && (cnt == 5'd0);
  assign o_cnt1              = pass_active && (cnt == CNT_STEP);
  assign o_shift_op          = (state != IDLE) && (op == OP_SHIFT);
  assign o_shift_counter_lsb = shamt[LB-1:0];

endmodule

`default_nettype wire

// File: tb/tb_qerv_bufreg_ctrl.sv
// ============================================================================
//  Module   : tb_qerv_bufreg_ctrl
//  Purpose  : Directed self-checking bench for qerv_bufreg_ctrl (BPC = 4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qerv_bufreg_ctrl;

  localparam int LB = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [4:0]    shamt;
  logic          ack;
  logic          ready;
  logic          done;
  logic [4:0]    cnt;
  logic          cnt0;
  logic          cnt1;
  logic          en;
  logic          init;
  logic          shift_op;
  logic [LB-1:0] lsb;
  logic          cyc;
`ifdef QERV_DBUS_TIMEOUT_EN
  logic          bus_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  wire [7:0] flags = {ready, done, en, init, cnt0, cnt1, cyc, shift_op};

  qerv_bufreg_ctrl #(.BITS_PER_CYCLE(4)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_start             (start),
    .i_op                (op),
    .i_shamt             (shamt),
    .i_dbus_ack          (ack),
    .o_ready             (ready),
    .o_done              (done),
    .o_cnt               (cnt),
    .o_cnt0              (cnt0),
    .o_cnt1              (cnt1),
    .o_bufreg_en         (en),
    .o_bufreg_init       (init),
    .o_shift_op          (shift_op),
    .o_shift_counter_lsb (lsb),
`ifdef QERV_DBUS_TIMEOUT_EN
    .o_bus_err           (bus_err),
`endif
    .o_dbus_cyc          (cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ack = 1'b0; op = 2'b00; shamt = 5'd0;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (flags !== 8'b1000_0000 || cnt !== 5'd0 || lsb !== 2'd0) begin
        miscompares++;
        $display("FAIL reset c=%0d flags=%b cnt=%0d lsb=%0d expected flags=10000000 cnt=0 lsb=0",
                 c, flags, cnt, lsb);
      end
      tick();
    end
  endtask

  // ADDR and the reserved encoding behave identically.
  task automatic test_addr(input logic [1:0] opc);
    logic [7:0] exp;
    logic [4:0] ecnt;
    op = opc; shamt = 5'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      exp  = {c == 10, c == 9, c <= 8, c <= 8, c == 1, c == 2, 1'b0, 1'b0};
      ecnt = (c <= 8) ? 5'((c - 1) * 4) : 5'd0;
      vectors++;
      if (flags !== exp || cnt !== ecnt) begin
        miscompares++;
        $display("FAIL addr op=%0d c=%0d flags=%b cnt=%0d expected flags=%b cnt=%0d",
                 opc, c, flags, cnt, exp, ecnt);
      end
      tick();
    end
  endtask

  task automatic test_shift(input logic [4:0] sh, input int k,
                            input logic [LB-1:0] elsb, input int done_at);
    logic [7:0] exp;
    logic [4:0] ecnt;
    logic       in_init, in_run;
    op = 2'b10; shamt = sh; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= done_at + 1; c++) begin
      in_init = (c <= 8);
      in_run  = (c > 8 + k) && (c < done_at);
      exp  = {c > done_at, c == done_at, c < done_at, in_init,
              (c == 1) || (c == 9 + k), (c == 2) || (c == 10 + k), 1'b0, c <= done_at};
      ecnt = in_init ? 5'((c - 1) * 4) : (in_run ? 5'((c - 9 - k) * 4) : 5'd0);
      vectors++;
      if (flags !== exp || cnt !== ecnt || (c <= done_at && lsb !== elsb)) begin
        miscompares++;
        $display("FAIL shift sh=%0d c=%0d flags=%b cnt=%0d lsb=%0d expected flags=%b cnt=%0d lsb=%0d",
                 sh, c, flags, cnt, lsb, exp, ecnt, elsb);
      end
      tick();
    end
  endtask

  // BUS entered at cycle 9, ack in cycle 14, stray ack in INIT cycle 3.
  task automatic test_mem();
    logic [7:0] exp;
    int cyc_cycles;
    cyc_cycles = 0;
    op = 2'b01; shamt = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      ack = (c == 3) || (c == 14);
      exp = {c == 24, c == 23, (c <= 8) || (c >= 15 && c <= 22), c <= 8,
             (c == 1) || (c == 15), (c == 2) || (c == 16), (c >= 9) && (c <= 14), 1'b0};
      if (cyc === 1'b1) cyc_cycles++;
      vectors++;
      if (flags !== exp) begin
        miscompares++;
        $display("FAIL mem c=%0d flags=%b expected flags=%b", c, flags, exp);
      end
      tick();
    end
    ack = 1'b0;
    vectors++;
    if (cyc_cycles !== 6) begin
      miscompares++;
      $display("FAIL mem_cyc_len got=%0d expected=6", cyc_cycles);
    end
  endtask

  // Start held high throughout, then reset in the middle of a RUN pass.
  task automatic test_back_to_back();
    logic [7:0] exp;
    op = 2'b10; shamt = 5'd1; start = 1'b1;
    tick();
    for (int c = 1; c <= 29; c++) begin
      exp = {c == 18, c == 17, (c <= 16) || (c >= 19),
             (c <= 8) || (c >= 19 && c <= 26),
             (c == 1) || (c == 9) || (c == 19) || (c == 27),
             (c == 2) || (c == 10) || (c == 20) || (c == 28),
             1'b0, c != 18};
      vectors++;
      if (flags !== exp || (c != 18 && lsb !== 2'd1)) begin
        miscompares++;
        $display("FAIL busy c=%0d flags=%b lsb=%0d expected flags=%b lsb=1", c, flags, lsb, exp);
      end
      if (c < 29) tick();
    end
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (flags !== 8'b1000_0000 || cnt !== 5'd0 || lsb !== 2'd0) begin
        miscompares++;
        $display("FAIL mid_reset c=%0d flags=%b cnt=%0d lsb=%0d expected flags=10000000 cnt=0 lsb=0",
                 c, flags, cnt, lsb);
      end
      tick();
    end
  endtask

`ifdef QERV_DBUS_TIMEOUT_EN
  // ack_at = 0 means no ack; BUS spans cycles 9..263.
  task automatic test_timeout(input int ack_at);
    int cyc_cycles;
    int done_at;
    logic exp_err;
    cyc_cycles = 0;
    done_at = (ack_at == 0) ? 264 : ack_at + 9;
    exp_err = (ack_at == 0);
    op = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= done_at + 1; c++) begin
      ack = (c == ack_at);
      if (cyc === 1'b1) cyc_cycles++;
      vectors++;
      if (done !== (c == done_at) || bus_err !== (c == done_at && exp_err)) begin
        miscompares++;
        $display("FAIL timeout ack_at=%0d c=%0d done=%b err=%b expected done=%b err=%b",
                 ack_at, c, done, bus_err, c == done_at, c == done_at && exp_err);
      end
      tick();
    end
    ack = 1'b0;
    vectors++;
    if (cyc_cycles !== 255) begin
      miscompares++;
      $display("FAIL timeout_cyc_len ack_at=%0d got=%0d expected=255", ack_at, cyc_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_addr(2'b00);
    test_addr(2'b11);
    test_shift(5'd13, 3, 2'd1, 20);
    test_shift(5'd2,  0, 2'd2, 17);
    test_shift(5'd31, 7, 2'd3, 24);
    test_mem();
    test_back_to_back();
`ifdef QERV_DBUS_TIMEOUT_EN
    test_timeout(0);
    test_timeout(263);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire

// File: doc/qerv_bufreg_ctrl.md
Name: qerv_bufreg_ctrl

Overview:
- Sequencer for the quad-serial buffer register in the qerv core.
- Accepts one operation at a time from the decoder/state logic.
- Drives the bufreg enable, init, cnt0/cnt1 and shift-counter controls through an address/operand init pass, an optional bus-wait or coarse-shift phase, and a readout pass. Signals completion with a one-cycle done pulse.

Parameters:
BITS_PER_CYCLE, 4, bits processed per cycle (power of two, 1..8)
LB, $clog2(BITS_PER_CYCLE), width of fine shift amount (min 1)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  start request; accepted only when o_ready=1
i_op  in  2  operation class: 00 ADDR, 01 MEM, 10 SHIFT, 11 reserved (treated as ADDR)
i_shamt  in  5  shift amount, SHIFT ops only
i_dbus_ack  in  1  data bus acknowledge
o_ready  out  1  controller idle, can accept i_start
o_done  out  1  one-cycle completion pulse
o_cnt  out  5  bit position of current slice (steps of BITS_PER_CYCLE)
o_cnt0  out  1  first slice of INIT or RUN pass
o_cnt1  out  1  second slice (o_cnt==BITS_PER_CYCLE) of INIT or RUN pass
o_bufreg_en  out  1  bufreg shift enable
o_bufreg_init  out  1  bufreg load-from-adder select
o_shift_op  out  1  current op is SHIFT
o_shift_counter_lsb  out  LB  fine shift amount, latched i_shamt[LB-1:0]
o_dbus_cyc  out  1  data bus cycle request

Behaviour:
- Clock and reset: one clock i_clk. i_rst is synchronous and active-high.
- Reset values: state IDLE, cnt=0, latched op/shamt=0, o_ready=1, all other outputs 0.
- Reset mid-operation: abort on the next edge, return to IDLE, o_done not pulsed.
- W = 32/BITS_PER_CYCLE slices per word (8 at default). cnt advances by BITS_PER_CYCLE per cycle in INIT and RUN and wraps 32-BPC -> 0 at end of pass. All arithmetic is modulo 32.
- States:
  - IDLE: o_ready=1. On i_start, latch i_op and i_shamt and go to INIT. i_start is ignored in all other states.
  - INIT: W cycles; o_bufreg_en=1, o_bufreg_init=1. On the last slice go to DONE (ADDR), BUS (MEM), SHIFT if i_shamt[4:LB]!=0, otherwise RUN (SHIFT).
  - BUS: o_dbus_cyc=1 (combinational from state), bufreg_en=0. i_dbus_ack with cyc high goes to RUN next cycle. Ack outside BUS is ignored. Ack in the first BUS cycle is legal.
  - SHIFT: coarse shift. Down-counter loaded with i_shamt[4:LB]. o_bufreg_en=1, init=0, cnt held at 0, o_cnt0/o_cnt1=0. Runs exactly i_shamt[4:LB] cycles, then RUN.
  - RUN: W cycles; o_bufreg_en=1, init=0. Last slice goes to DONE.
  - DONE: o_done=1 for one cycle, then IDLE. o_ready=0 in DONE, so back-to-back start is earliest the cycle after done.
- o_cnt0 = (INIT|RUN) & cnt==0. o_cnt1 = (INIT|RUN) & cnt==BITS_PER_CYCLE. Both are 0 elsewhere.
- o_shift_op = latched op==SHIFT while not IDLE. o_shift_counter_lsb = latched i_shamt[LB-1:0], stable from INIT through DONE.
- Latency, start accepted at edge T: INIT occupies T+1..T+W.
  - ADDR: done at T+W+1.
  - SHIFT: done at T+2W+k+1, where k = i_shamt[4:LB].
  - MEM: ack seen at cycle A gives RUN A+1..A+W, done A+W+1.

Optional Feature:
- Macro: QERV_DBUS_TIMEOUT_EN.
- When defined:
  - Add output o_bus_err (1 bit, reset 0) and an 8-bit watchdog cleared on BUS entry.
  - If BUS reaches 255 cycles without ack, drop o_dbus_cyc, go to DONE, and assert o_bus_err together with o_done for that one cycle.
  - Ack in the same cycle as timeout wins: normal RUN, no error.
- When undefined: no port o_bus_err, BUS waits indefinitely.

Test Plan:
- Reset, idle 3 cycles, start op=ADDR at T -> init/en=1 T+1..T+8; cnt0 at T+1, cnt1 at T+2; o_done only at T+9; o_ready=1 at T+10.
- op=SHIFT, shamt=13 (BPC=4) -> INIT 8 cycles; SHIFT 3 cycles with en=1, init=0; RUN 8 cycles; shift_counter_lsb=1 throughout; done at T+20.
- op=SHIFT, shamt=2 -> SHIFT skipped, RUN directly after INIT; lsb=2; done at T+17. Also check shamt=31: 7 coarse cycles, lsb=3.
- op=MEM, ack delayed 5 cycles after BUS entry -> cyc high exactly 6 cycles, en=0 during BUS; RUN 8 cycles; done 9 cycles after ack. A stray ack during INIT is ignored.
- i_start held high during a busy op, and i_rst asserted mid-RUN -> start ignored until DONE+1; after reset: o_ready=1, cnt=0, no done pulse.
- With QERV_DBUS_TIMEOUT_EN: no ack -> cyc drops after 255 cycles; o_done and o_bus_err both high one cycle. Repeat with ack in cycle 255 -> no error, normal RUN.
